// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, loader length limit and loader state encoding.
package cpu_pkg;
  localparam int CPU_ADDR_W    = 13;
  localparam int CPU_DATA_W    = 16;
  localparam int CPU_MAX_WORDS = 8192;
  typedef enum logic [2:0] {
    HDR_HI  = 3'd0,
    HDR_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    CHK     = 3'd4,
    RUN     = 3'd5,
    ERR     = 3'd6
  } ld_state_e;
endpackage

// File: rtl/ram_port_mux.sv
// ram_port_mux: hands the RAM port to the CPU once the loader's run flag is set.
module ram_port_mux
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W
) (
  input  logic              run_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic              ld_we_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic              cpu_we_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [DATA_W-1:0] ram_data_o
);
  assign ram_addr_o = run_i ? cpu_addr_i : ld_addr_i;
  assign ram_we_o   = run_i ? cpu_we_i   : ld_we_i;
  assign ram_data_o = run_i ? cpu_data_i : ld_data_i;
endmodule

// File: rtl/prog_loader.sv
// prog_loader: boot loader that streams a length-prefixed, XOR-checked program into RAM, then releases the CPU.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = CPU_ADDR_W,
  parameter int DATA_W    = CPU_DATA_W,
  parameter int MAX_WORDS = CPU_MAX_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_wrEn,
  input  logic [DATA_W-1:0] cpu_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wrEn,
  output logic [DATA_W-1:0] ram_data,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);
  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);
  ld_state_e         state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        xor_q, xor_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic              ld_we_q, ld_we_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;
  logic              run_q, err_q;
  logic              acc;
  logic [15:0]       hdr_n;
  logic              last_word;
  assign byte_ready = rst && (state_q inside {HDR_HI, HDR_LO, DATA_HI, DATA_LO, CHK});
  assign acc        = byte_valid && byte_ready;
  assign hdr_n      = {cnt_q[15:8], byte_in};
  assign last_word  = (16'(wc_q) + 16'd1) == cnt_q;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    xor_d     = xor_q;
    wc_d      = wc_q;
    ld_addr_d = ld_addr_q;
    ld_we_d   = 1'b0;
    ld_data_d = ld_data_q;
    if (acc) begin
      xor_d = (state_q == CHK) ? xor_q : xor_q ^ byte_in;
      case (state_q)
        HDR_HI: begin
          cnt_d[15:8] = byte_in;
          state_d     = HDR_LO;
        end
        HDR_LO: begin
          cnt_d[7:0] = byte_in;
          state_d    = (hdr_n > MAX_N) ? ERR : (hdr_n == 16'd0) ? CHK : DATA_HI;
        end
        DATA_HI: begin
          hi_d    = byte_in;
          state_d = DATA_LO;
        end
        DATA_LO: begin
          ld_we_d   = 1'b1;
          ld_addr_d = wc_q[ADDR_W-1:0];
          ld_data_d = DATA_W'({hi_q, byte_in});
          wc_d      = wc_q + 1'b1;
          state_d   = last_word ? CHK : DATA_HI;
        end
        CHK:     state_d = ((xor_q ^ byte_in) == 8'd0) ? RUN : ERR;
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= HDR_HI;
      cnt_q     <= '0;
      hi_q      <= '0;
      xor_q     <= '0;
      wc_q      <= '0;
      ld_addr_q <= '0;
      ld_we_q   <= 1'b0;
      ld_data_q <= '0;
      run_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      xor_q     <= xor_d;
      wc_q      <= wc_d;
      ld_addr_q <= ld_addr_d;
      ld_we_q   <= ld_we_d;
      ld_data_q <= ld_data_d;
      run_q     <= state_d == RUN;
      err_q     <= state_d == ERR;
    end
  end
  // run_q comes from next state, so the CPU is released on the same edge that accepts a good checksum.
  assign cpu_rst    = ~run_q;
  assign load_done  = run_q;
  assign err        = err_q;
  assign word_count = wc_q;
  ram_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .run_i     (run_q),
    .ld_addr_i (ld_addr_q),
    .ld_we_i   (ld_we_q),
    .ld_data_i (ld_data_q),
    .cpu_addr_i(cpu_addr),
    .cpu_we_i  (cpu_wrEn),
    .cpu_data_i(cpu_data),
    .ram_addr_o(ram_addr),
    .ram_we_o  (ram_wrEn),
    .ram_data_o(ram_data)
  );
endmodule
